modulo_transferidor_rolhas_param: RTL
=====================================

Name: modulo_transferidor_rolhas_param

Overview:
Parametrised cork-reservoir manager for the bottling line. It holds a principal reservoir count, which feeds the sealing MEF, and a secondary buffer count, which operators load. Corks move from secondary to principal one per clock in bounded batches. A batch starts automatically on low level, or on operator request. The block replaces the ad-hoc counter/comparator/pulser cluster and drives `ro` and the cork display encoders.

Parameters:
W, 7, width of both reservoir counts.
MAX, 99, capacity limit of each reservoir (must satisfy MAX < 2^W).
MIN_LEVEL, 5, auto-transfer threshold for the principal reservoir (MIN_LEVEL <= MAX).
BATCH, 15, maximum corks moved per transfer (1 <= BATCH <= MAX).

Ports:
clk  in  1  system clock (the divided clock clk_div at top level)
clr  in  1  synchronous active-high reset
enable  in  1  line running (start_stop); gates the start and continuation of transfers
load  in  1  one-cycle pulse: add load_valor corks to the secondary buffer
load_valor  in  W  corks to add on load
consumo  in  1  one-cycle pulse: one cork consumed by sealing (ve && cq)
req_manual  in  1  operator transfer request (level, sampled in IDLE)
modo_auto  in  1  1 = auto-start when principal < MIN_LEVEL
limpa_erro  in  1  clears erro_carga
principal  out  W  principal reservoir count (registered)
secundario  out  W  secondary buffer count (registered)
transferindo  out  1  1 while the FSM is in TRANSFER
fim  out  1  one-cycle pulse in DONE
ro  out  1  combinational: principal == 0
baixo_nivel  out  1  combinational: principal < MIN_LEVEL
erro_carga  out  1  sticky flag: a load was rejected

Behaviour:
- Reset (clr=1 at a clk edge) has top priority.
  - principal=0, secundario=0, batch counter=0, state=IDLE.
  - transferindo=0, fim=0, erro_carga=0.
  - Consequently ro=1 and baixo_nivel=1.
- FSM states: IDLE, TRANSFER, DONE.
- IDLE → TRANSFER when all of the following hold:
  - enable=1;
  - secundario>0;
  - principal<MAX;
  - (req_manual=1 or (modo_auto=1 and principal<MIN_LEVEL)).
- On entering TRANSFER, the batch counter is cleared. No cork moves on the IDLE→TRANSFER edge.
- TRANSFER, at each edge with enable=1: move one cork.
  - principal+1, secundario-1, batch+1.
  - The move is skipped if secundario==0 or principal==MAX.
- TRANSFER → DONE on the edge where any of these is true:
  - the move makes batch==BATCH;
  - secundario reaches 0;
  - principal reaches MAX;
  - enable=0 (abort; no move on that edge).
- DONE: fim=1 for exactly one cycle, then IDLE.
  - A new start is evaluated only from IDLE, so there are at least 2 idle cycles between batches (DONE plus one IDLE cycle).
- Latency: start condition true in cycle N → transferindo=1 from N+1 → first increment visible at N+2.
- consumo:
  - If principal>0, principal decrements.
  - If it coincides with a move, the net principal change is 0 while secundario still decrements and batch still counts.
  - If principal==0, consumo is ignored.
- load, accepted in any state:
  - The sum is computed at W+1 bits as secundario + load_valor, using the pre-decrement value.
  - If sum <= MAX: secundario takes the new value, minus 1 if a move occurs on the same edge.
  - Otherwise the load is rejected: secundario is unaffected by the load and erro_carga is set to 1.
  - load_valor=0 has no effect and raises no error.
- erro_carga stays 1 until limpa_erro=1 or clr. If limpa_erro and a rejected load occur on the same edge, set wins.
- A load arriving during TRANSFER extends eligibility: the batch continues if secundario would otherwise reach 0.
- Neither count wraps. principal is held ≤ MAX and ≥ 0; secundario is held ≤ MAX and ≥ 0.
- clr mid-TRANSFER: state returns to IDLE and both counts go to 0 on that edge; no fim pulse.

Test Plan:
1. Reset, then idle 5 cycles → principal=0, secundario=0, ro=1, baixo_nivel=1, transferindo=0, fim=0, erro_carga=0.
2. enable=1, modo_auto=1, load 40:
   - secundario=40 next cycle;
   - transferindo=1 one cycle later;
   - after 15 moves: principal=15, secundario=25, one fim pulse;
   - FSM then stays IDLE (15 ≥ 5).
3. secundario=50, load 60 → rejected: secundario=50, erro_carga=1; limpa_erro → erro_carga=0; then load 49 → secundario=99.
4. During a transfer with principal=3, pulse consumo for 4 consecutive move cycles → principal stays 3 across those cycles while secundario drops by 4.
5. principal=95, secundario=20, req_manual=1 → 4 moves → principal=99, secundario=16, DONE after the 4th move. A second req_manual does not start (principal==MAX).
6. Mid-transfer with principal=7, secundario=30:
   - drop enable → no further moves, fim pulse, counts frozen;
   - in a repeat run, assert clr mid-transfer → principal=0, secundario=0, state IDLE, no fim.

Source files
------------

// File: rtl/modulo_transferidor_rolhas_param.sv
// rtl/modulo_transferidor_rolhas_param.sv - cork reservoir manager: secondary-to-principal batch transfer
module modulo_transferidor_rolhas_param #(
  parameter int W         = 7,
  parameter int MAX       = 99,
  parameter int MIN_LEVEL = 5,
  parameter int BATCH     = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_valor,
  input  logic         consumo,
  input  logic         req_manual,
  input  logic         modo_auto,
  input  logic         limpa_erro,
  output logic [W-1:0] principal,
  output logic [W-1:0] secundario,
  output logic         transferindo,
  output logic         fim,
  output logic         ro,
  output logic         baixo_nivel,
  output logic         erro_carga
);

  localparam logic [W-1:0] MAX_V   = W'(MAX);
  localparam logic [W-1:0] MIN_V   = W'(MIN_LEVEL);
  localparam logic [W-1:0] BATCH_V = W'(BATCH);
  localparam logic [W-1:0] ONE_V   = W'(1);
  localparam logic [W:0]   SOMA_MAX = (W+1)'(MAX);

  typedef enum logic [1:0] {S_IDLE, S_TRANSFER, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] principal_q, principal_d;
  logic [W-1:0] secundario_q, secundario_d;
  logic [W-1:0] batch_q, batch_d;
  logic         erro_q, erro_d;

  logic [W:0]   soma;
  logic         load_ok, load_rej, start, move, consome;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      principal_q  <= '0;
      secundario_q <= '0;
      batch_q      <= '0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      principal_q  <= principal_d;
      secundario_q <= secundario_d;
      batch_q      <= batch_d;
      erro_q       <= erro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    move    = 1'b0;

    // Load sum is taken on the pre-move value, one bit wider to catch overflow.
    soma     = {1'b0, secundario_q} + {1'b0, load_valor};
    load_ok  = load && (load_valor != '0) && (soma <= SOMA_MAX);
    load_rej = load && (load_valor != '0) && (soma > SOMA_MAX);
    consome  = consumo && (principal_q != '0);
    start    = enable && (secundario_q != '0) && (principal_q < MAX_V) &&
               (req_manual || (modo_auto && (principal_q < MIN_V)));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRANSFER;
          batch_d = '0;
        end
      end
      S_TRANSFER: begin
        if (!enable) begin
          state_d = S_DONE;
        end else begin
          move = (secundario_q != '0) && (principal_q < MAX_V);
          if (move) batch_d = batch_q + ONE_V;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    principal_d = principal_q;
    if (move && !consome)      principal_d = principal_q + ONE_V;
    else if (!move && consome) principal_d = principal_q - ONE_V;

    secundario_d = (load_ok ? soma[W-1:0] : secundario_q) - (move ? ONE_V : '0);

    // End conditions look at the post-edge counts so a concurrent load keeps the batch alive.
    if (state_q == S_TRANSFER && enable &&
        ((move && batch_d == BATCH_V) || secundario_d == '0 || principal_d == MAX_V))
      state_d = S_DONE;

    if (load_rej)        erro_d = 1'b1;
    else if (limpa_erro) erro_d = 1'b0;
    else                 erro_d = erro_q;
  end

  assign principal    = principal_q;
  assign secundario   = secundario_q;
  assign transferindo = (state_q == S_TRANSFER);
  assign fim          = (state_q == S_DONE);
  assign ro           = (principal_q == '0);
  assign baixo_nivel  = (principal_q < MIN_V);
  assign erro_carga   = erro_q;

endmodule
